tinyalu_responder: RTL and testbench
====================================

// Module: tinyalu_responder
// PURPOSE
//  Responder end of the TinyALU start/done operation protocol; the synthesizable ALU the BFM drives.
//  Captures A/B/op on start, computes ADD/AND/XOR in 1 cycle and MUL in a pipelined multiplier.
//  Pulses done with a registered 16-bit result.
//  Sits under the tinyalu top, which connects it to the tinyalu_bfm interface signals.
// PARAMETERS
//  DATA_W       8   operand width; result width is 2*DATA_W
//  MUL_LATENCY  3   capture-edge-to-done cycles for MUL (>=2); single-cycle ops fixed at 1
// PORTS
//  clk      in   1         single clock, all logic on posedge
//  reset    in   1         asynchronous, active-high; clears all state
//  A        in   DATA_W    operand A, sampled on the capture edge only
//  B        in   DATA_W    operand B, sampled on the capture edge only
//  op       in   3         operation_t encoding: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101/110/111 illegal
//  start    in   1         request; held high by the initiator until done is seen
//  done     out  1         one-cycle pulse; result valid in the same cycle
//  result   out  2*DATA_W  registered result, held until the next done
//  op_err   out  1         only with TINYALU_RESP_OPERR_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset values: done=0, result=0, op_err=0, FSM=IDLE, multiplier pipeline valid bits cleared.
//  FSM states and transitions:
//   IDLE: start=1 at posedge T -> capture A, B, op.
//     - add/and/xor -> EXEC
//     - mul -> MUL
//     - no_op/illegal -> WAIT_LOW (no done, result unchanged)
//   EXEC: edge T+1 -> result, done=1; -> WAIT_LOW.
//   MUL: count MUL_LATENCY-1 cycles; at edge T+MUL_LATENCY -> result, done=1; -> WAIT_LOW.
//   WAIT_LOW: done=0; stay while start=1; start=0 -> IDLE.
//  WAIT_LOW rules:
//   - No retrigger from a start held high past done.
//   - Back-to-back ops require >=1 posedge with start=0 (initiator guarantees this).
//  Arithmetic, all unsigned, zero-extended to 2*DATA_W:
//   - add: carry lands in bit DATA_W.
//   - and/xor: upper half 0.
//   - mul: full 2*DATA_W product, no truncation.
//  Input changes outside the capture edge are ignored:
//   - A/B/op changing during EXEC/MUL do not affect result.
//   - start dropping mid-MUL does not abort; done still pulses.
//  Reset mid-operation:
//   - Immediate clear; in-flight op discarded, no done.
//   - First edge after release is in IDLE; start=1 there is accepted.
//  done is never asserted for two consecutive cycles.
//  done is never asserted without a preceding capture.
// CONFIGURATION
//  TINYALU_RESP_OPERR_EN defined:
//   - op_err port present; pulses 1 cycle at T+1 when an illegal op (101/110/111) is captured.
//   - No done; result unchanged.
//  TINYALU_RESP_OPERR_EN undefined:
//   - op_err port absent; illegal ops are treated exactly as no_op.
// STRUCTURE
//  tinyalu_pkg: reuse operation_t.
//  tinyalu_pkg additions:
//   - resp_state_t (IDLE, EXEC, MUL, WAIT_LOW).
//   - localparam OP_W=3.
//  Sub-module tinyalu_resp_mul: DATA_W x DATA_W pipelined multiplier with valid shift register.
//   - Depth MUL_LATENCY-1.
//   - Cleared by reset.
//  The FSM, operand capture and result mux stay in tinyalu_responder.
// TESTING
//  add A=8'hFF B=8'h01, start held -> done at T+1 only, result=16'h0100, then done=0.
//  mul A=8'hFF B=8'hFF -> done at T+3 (MUL_LATENCY=3), result=16'hFE01; no done at T+1/T+2.
//  and 8'hF0,8'h3C -> result 16'h0030; then xor 8'hAA,8'hFF -> 16'h0055.
//   - Second op is started one low cycle after the first done.
//  start held 10 cycles after add done -> exactly one done pulse; no retrigger.
//  reset asserted at T+1 of mul 8'h10*8'h10 -> no done, result=0.
//   - Next add 8'h02+8'h03 after release -> 16'h0005 at T+1.
//  no_op and op=3'b111 with start -> no done, result unchanged.
//   - With TINYALU_RESP_OPERR_EN: op_err=1 for 111 only, for one cycle.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: operation encoding, responder FSM states, op width.
package tinyalu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        WAIT_LOW
    } resp_state_t;

    // Encodings 101..111 are outside operation_t.
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > mul_op;
    endfunction

endpackage

// File: rtl/tinyalu_responder_if.sv
// TinyALU start/done bus; op_err exists only when TINYALU_RESP_OPERR_EN is defined.
interface tinyalu_responder_if #(parameter int DATA_W = 8);
    import tinyalu_pkg::*;

    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    logic [OP_W-1:0]     op;
    logic                start;
    logic                done;
    logic [2*DATA_W-1:0] result;
`ifdef TINYALU_RESP_OPERR_EN
    logic                op_err;

    modport master (output A, B, op, start, input done, result, op_err);
    modport slave  (input A, B, op, start, output done, result, op_err);
`else
    modport master (output A, B, op, start, input done, result);
    modport slave  (input A, B, op, start, output done, result);
`endif

endinterface

// File: rtl/tinyalu_resp_mul.sv
// Pipelined unsigned multiplier: DEPTH register stages, valid travels alongside the product.
module tinyalu_resp_mul #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_vld,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                out_vld,
    output logic [2*DATA_W-1:0] prod
);
    localparam int STAGES = DEPTH - 1;
    localparam int RW     = 2 * DATA_W;

    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0][RW-1:0] prod_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            prod_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_vld;
            prod_pipe[0] <= RW'(a) * RW'(b);
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                prod_pipe[i] <= prod_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[STAGES];
    assign prod    = prod_pipe[STAGES];

endmodule

// File: rtl/tinyalu_responder.sv
// TinyALU responder: captures A/B/op on start, pulses done with a registered result.
// Optional TINYALU_RESP_OPERR_EN adds an op_err pulse for illegal op encodings.
module tinyalu_responder
    import tinyalu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic             clk,
    input  logic             reset,
    tinyalu_responder_if.slave bus
);
    localparam int RW = 2 * DATA_W;

    resp_state_t       state, state_nxt;
    logic [DATA_W-1:0] a_q, b_q;
    logic [OP_W-1:0]   op_q;
    logic              capture;
    logic              mul_go, mul_go_nxt;
    logic              done_q, done_nxt;
    logic [RW-1:0]     result_q, result_nxt;
    logic [RW-1:0]     alu_res;
    logic              mul_vld;
    logic [RW-1:0]     mul_prod;

    // Multiplier is fed from the captured operands one edge after capture,
    // so its DEPTH = MUL_LATENCY-1 stages plus the result register give MUL_LATENCY.
    tinyalu_resp_mul #(.DATA_W(DATA_W), .DEPTH(MUL_LATENCY - 1)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .in_vld (mul_go),
        .a      (a_q),
        .b      (b_q),
        .out_vld(mul_vld),
        .prod   (mul_prod)
    );

    always_comb begin
        alu_res = '0;
        case (op_q)
            add_op:  alu_res = RW'(a_q) + RW'(b_q);
            and_op:  alu_res = RW'(a_q & b_q);
            xor_op:  alu_res = RW'(a_q ^ b_q);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        mul_go_nxt = 1'b0;
        done_nxt   = 1'b0;
        result_nxt = result_q;
        case (state)
            IDLE: if (bus.start) begin
                capture = 1'b1;
                if (bus.op == add_op || bus.op == and_op || bus.op == xor_op) begin
                    state_nxt = EXEC;
                end else if (bus.op == mul_op) begin
                    state_nxt  = MUL;
                    mul_go_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT_LOW;
                end
            end
            EXEC: begin
                result_nxt = alu_res;
                done_nxt   = 1'b1;
                state_nxt  = WAIT_LOW;
            end
            MUL: if (mul_vld) begin
                result_nxt = mul_prod;
                done_nxt   = 1'b1;
                state_nxt  = WAIT_LOW;
            end
            WAIT_LOW: if (!bus.start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mul_go   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_nxt;
            mul_go   <= mul_go_nxt;
            done_q   <= done_nxt;
            result_q <= result_nxt;
            if (capture) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.op;
            end
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;

`ifdef TINYALU_RESP_OPERR_EN
    // err_pend marks the capture edge; op_err follows one edge later, aligned with where done would be.
    logic err_pend, op_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pend <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            err_pend <= capture && op_illegal(bus.op);
            op_err_q <= err_pend;
        end
    end

    assign bus.op_err = op_err_q;
`endif

endmodule

// File: tb/tb_tinyalu_responder.sv
// Scoreboard bench for tinyalu_responder: driver pushes expected results, negedge monitor checks.
module tb_tinyalu_responder;
    import tinyalu_pkg::*;

    localparam int DATA_W = 8;
    localparam int ML     = 3;

    typedef struct {
        logic [15:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t e;
    logic [15:0] model_res = '0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tinyalu_responder_if #(.DATA_W(DATA_W)) bus ();

    tinyalu_responder #(.DATA_W(DATA_W), .MUL_LATENCY(ML)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unsigned arithmetic on integers, truncated to the 16-bit result.
    function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, output bit has);
        int ia, ib;
        ia  = int'(a);
        ib  = int'(b);
        has = 1'b1;
        case (op)
            3'd1: return 16'(ia + ib);
            3'd2: return 16'(ia & ib);
            3'd3: return 16'(ia ^ ib);
            3'd4: return 16'(ia * ib);
            default: begin
                has = 1'b0;
                return 16'h0;
            end
        endcase
    endfunction

    function automatic string op_name(input logic [2:0] op);
        case (op)
            3'd1: return "add";
            3'd2: return "and";
            3'd3: return "xor";
            3'd4: return "mul";
            default: return "nop";
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            check("reset_done", {31'b0, bus.done}, 0);
            check("reset_result", {16'b0, bus.result}, 0);
            model_res = '0;
        end else if (bus.done) begin
            check("done_back_to_back", {31'b0, done_prev}, 0);
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, bus.done}, 0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, {16'b0, bus.result}, {16'b0, e.res});
                check({e.name, "_latency"}, cyc, e.cyc);
                model_res = e.res;
            end
        end else begin
            check("result_held", {16'b0, bus.result}, {16'b0, model_res});
        end
        done_prev = bus.done;
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input int hold, input int low, input bit nowait);
        bit          has;
        bit          got;
        logic [15:0] r;
        int          t;
        if (!nowait) begin
            @(posedge clk);
            #1;
        end
        bus.A     = a;
        bus.B     = b;
        bus.op    = op;
        bus.start = 1'b1;
        t = cyc + 1;
        r = ref_alu(a, b, op, has);
        if (has) sb.push_back('{r, t + ((op == 3'd4) ? ML : 1), op_name(op)});
        @(posedge clk);
        #1;
        // Operands wander after capture; the result must not follow them.
        bus.A  = 8'($urandom);
        bus.B  = 8'($urandom);
        bus.op = 3'($urandom);
        if (has) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = bus.done;
            end
            if (!got) check({op_name(op), "_done_timeout"}, {31'b0, got}, 1);
            repeat (hold) @(posedge clk);
        end else begin
            repeat (ML + 2) @(posedge clk);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (low) @(posedge clk);
    endtask

    initial begin
        bus.A     = '0;
        bus.B     = '0;
        bus.op    = '0;
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        do_op(8'hFF, 8'h01, 3'd1, 2, 1, 1'b0);
        do_op(8'hFF, 8'hFF, 3'd4, 0, 1, 1'b0);
        do_op(8'hF0, 8'h3C, 3'd2, 0, 1, 1'b0);
        do_op(8'hAA, 8'hFF, 3'd3, 0, 1, 1'b0);
        do_op(8'h12, 8'h34, 3'd1, 10, 1, 1'b0);

        // Reset lands mid-multiply; nothing is expected from it.
        @(posedge clk);
        #1;
        bus.A     = 8'h10;
        bus.B     = 8'h10;
        bus.op    = 3'd4;
        bus.start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_op(8'h02, 8'h03, 3'd1, 0, 1, 1'b1);

        do_op(8'h55, 8'h66, 3'd0, 0, 1, 1'b0);
        do_op(8'h55, 8'h66, 3'd7, 0, 1, 1'b0);

        repeat (40) begin
            do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        repeat (6) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
